// File: rtl/hazard_ctrl.sv
// Stall/forward controller for a 5-stage MIPS pipeline using Tuse/Tnew scheduling.
// Define HAZARD_FWD_EN to enable the bypass network; otherwise operands wait for W to retire.
module hazard_ctrl #(
    parameter int AW    = 5,
    parameter int TW    = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [AW-1:0]    d_a1,
    input  logic [AW-1:0]    d_a2,
    input  logic [TW-1:0]    d_tuse1,
    input  logic [TW-1:0]    d_tuse2,
    input  logic [AW-1:0]    d_a3,
    input  logic [TW-1:0]    d_tnew,
    output logic             stall,
    output logic [1:0]       fwd_d1,
    output logic [1:0]       fwd_d2,
    output logic [1:0]       fwd_e1,
    output logic [1:0]       fwd_e2,
    output logic [AW-1:0]    e_a3,
    output logic [AW-1:0]    m_a3,
    output logic [AW-1:0]    w_a3,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [TW-1:0] TNEW_ONE = TW'(1);

    logic [AW-1:0]    r_e_a1, r_e_a2, r_e_a3, r_m_a3, r_w_a3;
    logic [TW-1:0]    r_e_tnew, r_m_tnew, r_w_tnew;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [AW-1:0] w_d_a    [2];
    logic [TW-1:0] w_d_tuse [2];
    logic [AW-1:0] w_e_a    [2];
    logic [1:0]    w_fwd_d  [2];
    logic [1:0]    w_fwd_e  [2];
    logic [1:0]    w_stall_src;
    logic          w_stall;

    function automatic logic [TW-1:0] dec(input logic [TW-1:0] t);
        return (t == '0) ? '0 : t - TNEW_ONE;
    endfunction

    assign w_d_a[0]    = d_a1;
    assign w_d_a[1]    = d_a2;
    assign w_d_tuse[0] = d_tuse1;
    assign w_d_tuse[1] = d_tuse2;
    assign w_e_a[0]    = r_e_a1;
    assign w_e_a[1]    = r_e_a2;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic w_e_hit, w_m_hit, w_w_hit;
            // Register 0 is never a real dependency, so a zero address can never match.
            assign w_e_hit = (w_d_a[gi] != '0) && (r_e_a3 == w_d_a[gi]);
            assign w_m_hit = (w_d_a[gi] != '0) && (r_m_a3 == w_d_a[gi]);
            assign w_w_hit = (w_d_a[gi] != '0) && (r_w_a3 == w_d_a[gi]);
`ifdef HAZARD_FWD_EN
            logic w_em_hit, w_ew_hit;
            assign w_stall_src[gi] = (w_e_hit && (r_e_tnew > w_d_tuse[gi])) ||
                                     (w_m_hit && (r_m_tnew > w_d_tuse[gi]));
            // Only the nearest matching producer counts; if not ready, the stall covers it.
            assign w_fwd_d[gi] = w_e_hit ? ((r_e_tnew == '0) ? 2'd1 : 2'd0) :
                                 w_m_hit ? ((r_m_tnew == '0) ? 2'd2 : 2'd0) :
                                 (w_w_hit && (r_w_tnew == '0)) ? 2'd3 : 2'd0;
            assign w_em_hit = (w_e_a[gi] != '0) && (r_m_a3 == w_e_a[gi]);
            assign w_ew_hit = (w_e_a[gi] != '0) && (r_w_a3 == w_e_a[gi]);
            assign w_fwd_e[gi] = (w_em_hit && (r_m_tnew == '0)) ? 2'd1 :
                                 (w_ew_hit && (r_w_tnew == '0)) ? 2'd2 : 2'd0;
`else
            assign w_stall_src[gi] = w_e_hit || w_m_hit || w_w_hit;
            assign w_fwd_d[gi]     = 2'd0;
            assign w_fwd_e[gi]     = 2'd0;
`endif
        end
    endgenerate

`ifndef HAZARD_FWD_EN
    logic w_unused_nofwd;
    assign w_unused_nofwd = ^{d_tuse1, d_tuse2, r_e_a1, r_e_a2, r_w_tnew};
`endif

    assign w_stall = |w_stall_src;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_e_a1   <= '0;
            r_e_a2   <= '0;
            r_e_a3   <= '0;
            r_e_tnew <= '0;
            r_m_a3   <= '0;
            r_m_tnew <= '0;
            r_w_a3   <= '0;
            r_w_tnew <= '0;
        end else begin
            if (w_stall) begin
                r_e_a1   <= '0;
                r_e_a2   <= '0;
                r_e_a3   <= '0;
                r_e_tnew <= '0;
            end else begin
                r_e_a1   <= d_a1;
                r_e_a2   <= d_a2;
                r_e_a3   <= d_a3;
                r_e_tnew <= dec(d_tnew);
            end
            r_m_a3   <= r_e_a3;
            r_m_tnew <= dec(r_e_tnew);
            r_w_a3   <= r_m_a3;
            r_w_tnew <= dec(r_m_tnew);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign stall     = w_stall;
    assign fwd_d1    = w_fwd_d[0];
    assign fwd_d2    = w_fwd_d[1];
    assign fwd_e1    = w_fwd_e[0];
    assign fwd_e2    = w_fwd_e[1];
    assign e_a3      = r_e_a3;
    assign m_a3      = r_m_a3;
    assign w_a3      = r_w_a3;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl (4-bit stall counter); expectations follow HAZARD_FWD_EN.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] d_a1, d_a2, d_a3;
    logic [2:0] d_tuse1, d_tuse2, d_tnew;
    logic       stall;
    logic [1:0] fwd_d1, fwd_d2, fwd_e1, fwd_e2;
    logic [4:0] e_a3, m_a3, w_a3;
    logic [3:0] stall_cnt;

    always #5 clk = ~clk;

    hazard_ctrl #(.AW(5), .TW(3), .CNT_W(4)) dut (
        .clk(clk), .reset(reset),
        .d_a1(d_a1), .d_a2(d_a2), .d_tuse1(d_tuse1), .d_tuse2(d_tuse2),
        .d_a3(d_a3), .d_tnew(d_tnew),
        .stall(stall), .fwd_d1(fwd_d1), .fwd_d2(fwd_d2), .fwd_e1(fwd_e1), .fwd_e2(fwd_e2),
        .e_a3(e_a3), .m_a3(m_a3), .w_a3(w_a3), .stall_cnt(stall_cnt)
    );

    typedef struct {
        string tag;
        int    st, fd1, fd2, fe1, fe2, ea3, ma3, wa3, cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_e = 0, exp_m = 0, exp_w = 0, exp_cnt = 0;
    bit   chk_en = 1'b0;
    int   fe_lw;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One D-stage cycle: drive, queue the expectation, compare mid-cycle, then advance the model.
    task automatic cyc(input string tag, input int a1, input int a2, input int t1, input int t2,
                       input int a3, input int tn,
                       input int st, input int fd1, input int fd2, input int fe1, input int fe2);
        exp_t x, y;
        d_a1 = 5'(a1); d_a2 = 5'(a2); d_tuse1 = 3'(t1); d_tuse2 = 3'(t2);
        d_a3 = 5'(a3); d_tnew = 3'(tn);
        x.tag = tag; x.st = st; x.fd1 = fd1; x.fd2 = fd2; x.fe1 = fe1; x.fe2 = fe2;
        x.ea3 = exp_e; x.ma3 = exp_m; x.wa3 = exp_w; x.cnt = exp_cnt;
        if (chk_en) sb.push_back(x);
        @(negedge clk);
        if (chk_en && sb.size() > 0) begin
            y = sb.pop_front();
            check({y.tag, ".stall"},  int'(stall),     y.st);
            check({y.tag, ".fwd_d1"}, int'(fwd_d1),    y.fd1);
            check({y.tag, ".fwd_d2"}, int'(fwd_d2),    y.fd2);
            check({y.tag, ".fwd_e1"}, int'(fwd_e1),    y.fe1);
            check({y.tag, ".fwd_e2"}, int'(fwd_e2),    y.fe2);
            check({y.tag, ".e_a3"},   int'(e_a3),      y.ea3);
            check({y.tag, ".m_a3"},   int'(m_a3),      y.ma3);
            check({y.tag, ".w_a3"},   int'(w_a3),      y.wa3);
            check({y.tag, ".cnt"},    int'(stall_cnt), y.cnt);
            $display("cycle %-8s a1=%0d a2=%0d a3=%0d stall=%0d fd=%0d/%0d fe=%0d/%0d cnt=%0d",
                     y.tag, a1, a2, a3, stall, fwd_d1, fwd_d2, fwd_e1, fwd_e2, stall_cnt);
        end
        @(posedge clk);
        if (!reset) begin
            exp_e = 0; exp_m = 0; exp_w = 0; exp_cnt = 0;
        end else begin
            exp_w = exp_m;
            exp_m = exp_e;
            exp_e = (st != 0) ? 0 : a3;
            if (st != 0 && exp_cnt < 15) exp_cnt++;
        end
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) cyc("nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        // Reset held two cycles with busy inputs; only the second cycle has a known shadow state.
        cyc("rst0", 2, 3, 1, 1, 4, 3, 0, 0, 0, 0, 0);
        chk_en = 1'b1;
        cyc("rst1", 2, 3, 1, 1, 4, 3, 0, 0, 0, 0, 0);
        reset = 1'b1;
        drain();

        // Reset asserted while a load-use stall is active
        cyc("rs_lw", 29, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("rs_use", 2, 0, 1, 0, 7, 2, 1, 0, 0, 0, 0);
        reset = 1'b1;
        cyc("rs_post", 2, 0, 1, 0, 7, 2, 0, 0, 0, 0, 0);
        cyc("rs_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // lw $2 then addu reading $2
        cyc("t2_lw", 29, 0, 1, 0, 2, 3, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        cyc("t2_use", 2, 3, 1, 1, 7, 2, 1, 0, 0, 0, 0);
        cyc("t2_use", 2, 3, 1, 1, 7, 2, 0, 0, 0, 0, 0);
        cyc("t2_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
`else
        for (int i = 0; i < 3; i++) cyc("t2_use", 2, 3, 1, 1, 7, 2, 1, 0, 0, 0, 0);
        cyc("t2_go", 2, 3, 1, 1, 7, 2, 0, 0, 0, 0, 0);
        cyc("t2_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain();

        // addu $4 then beq $4,$4
        cyc("t3_addu", 8, 9, 1, 1, 4, 2, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        cyc("t3_beq", 4, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t3_beq", 4, 4, 0, 0, 0, 0, 0, 2, 2, 0, 0);
        cyc("t3_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2);
`else
        for (int i = 0; i < 3; i++) cyc("t3_beq", 4, 4, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc("t3_go", 4, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t3_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain();

        // Non-writing producer followed by readers of $0
        cyc("t4_wr", 1, 0, 1, 0, 0, 2, 0, 0, 0, 0, 0);
        cyc("t4_rd0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("t4_rd0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drain();

        // ori $5; ori $5; sw reads $5 as rt: the nearest producer must win
        cyc("t5_ori1", 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
        cyc("t5_ori2", 1, 0, 1, 0, 5, 1, 0, 0, 0, 0, 0);
`ifdef HAZARD_FWD_EN
        cyc("t5_sw", 29, 5, 1, 2, 0, 0, 0, 0, 1, 0, 0);
        cyc("t5_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
`else
        for (int i = 0; i < 3; i++) cyc("t5_sw", 29, 5, 1, 2, 0, 0, 1, 0, 0, 0, 0);
        cyc("t5_go", 29, 5, 1, 2, 0, 0, 0, 0, 0, 0, 0);
        cyc("t5_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
        drain();

        // Repeated load-use pairs drive the 4-bit counter into saturation
`ifdef HAZARD_FWD_EN
        fe_lw = 0;
        for (int n = 0; n < 20; n++) begin
            cyc("t6_lw", 29, 0, 1, 0, 2, 3, 0, 0, 0, fe_lw, 0);
            cyc("t6_use", 2, 0, 1, 0, 7, 2, 1, 0, 0, 0, 0);
            cyc("t6_use", 2, 0, 1, 0, 7, 2, 0, 0, 0, 0, 0);
            cyc("t6_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0);
            fe_lw = 0;
        end
`else
        fe_lw = 0;
        for (int n = 0; n < 7; n++) begin
            cyc("t6_lw", 29, 0, 1, 0, 2, 3, 0, 0, 0, fe_lw, 0);
            for (int i = 0; i < 3; i++) cyc("t6_use", 2, 0, 1, 0, 7, 2, 1, 0, 0, 0, 0);
            cyc("t6_go", 2, 0, 1, 0, 7, 2, 0, 0, 0, 0, 0);
            cyc("t6_nop", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        end
`endif
        cyc("t6_end", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("t6.sat", int'(stall_cnt), 15);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
